// File: rtl/rd_ptr_empty.sv
// rd_ptr_empty: read-domain pointer, empty/almost-empty flags, fill level and pop-on-empty error
module rd_ptr_empty #(
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                  rd_clk,
  input  logic                  rst_in_rd,
  input  logic                  rd_en_in,
  input  logic                  pop_req,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_in,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  pop_on_empty_error
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] TH = PW'(ALMOST_EMPTY_TH);
  logic [PW-1:0] wq1_q, wq2_q, wbin_s;
  logic [PW-1:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
  logic [PW-1:0] rd_level_q, rd_level_d;
  logic          empty_q, almost_empty_q, err_q;
  // Gray-to-binary of the synchronised write pointer, then next read pointer and level
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) wbin_s[i] = ^(wq2_q >> i);
    rd_bin_d   = rd_bin_q + PW'(rd_en_in & ~empty_q);
    rd_gray_d  = rd_bin_d ^ (rd_bin_d >> 1);
    rd_level_d = wbin_s - rd_bin_d;
  end
  // Synchroniser, pointers, flags and error pulse; async reset leaves the FIFO looking empty
  always_ff @(posedge rd_clk or posedge rst_in_rd) begin
    if (rst_in_rd) begin
      wq1_q          <= '0;
      wq2_q          <= '0;
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      err_q          <= 1'b0;
    end else begin
      wq1_q          <= wr_ptr_gray_in;
      wq2_q          <= wq1_q;
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      rd_level_q     <= rd_level_d;
      empty_q        <= (rd_gray_d == wq2_q);
      almost_empty_q <= (rd_level_d <= TH);
      err_q          <= pop_req & empty_q;
    end
  end
  assign rd_addr            = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray        = rd_gray_q;
  assign empty              = empty_q;
  assign almost_empty       = almost_empty_q;
  assign rd_level           = rd_level_q;
  assign pop_on_empty_error = err_q;
endmodule
